tbu_ctrl: RTL and testbench
===========================

TBU_CTRL -- requirements
Module: tbu_ctrl

Interface
REQ-001 Parameter DEPTH, default 48: total traceback steps per run.
REQ-002 Parameter DECODE_LEN, default 24: bits emitted per run; the first DEPTH-DECODE_LEN steps are for convergence only.
REQ-003 Parameter ADDR_W, default 6: survivor RAM address width; the RAM is circular with 2^ADDR_W entries.
REQ-004 Ports (clock and reset first):
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  di_start  in  1  one-cycle run request
  di_wr_ptr  in  ADDR_W  address of newest survivor word
  di_best_state  in  6  initial trellis state from the SDS unit
  do_busy  out  1  run in progress
  do_ram_rd  out  1  survivor RAM read enable
  do_ram_addr  out  ADDR_W  survivor RAM read address
  di_ram_data  in  64  survivor word; 1-cycle read latency; bit i = survivor of state i
  do_valid  out  1  decoded bit valid
  do_bit  out  1  decoded bit
  do_last  out  1  final bit of run
  di_ready  in  1  downstream accepts bit

Function
REQ-005 FSM states: IDLE, TRACE, OUTPUT.
REQ-006 IDLE->TRACE when di_start=1: latch di_wr_ptr as the address and the initial state; do_busy=1 from the next cycle.
REQ-007 di_start is ignored outside IDLE; no queuing.
REQ-008 TRACE issues DEPTH consecutive reads, one per cycle, at addresses wr_ptr, wr_ptr-1, ..., wr_ptr-DEPTH+1, modulo 2^ADDR_W (wraps 0->2^ADDR_W-1).
REQ-009 Step k, data arriving the cycle after read k: bit_k = state[5]; state <= {state[4:0], di_ram_data[state]}.
REQ-010 For steps k >= DEPTH-DECODE_LEN, bit_k is pushed into an internal DECODE_LEN-entry LIFO; earlier bits are discarded.
REQ-011 TRACE lasts exactly DEPTH+1 cycles (read pipeline drain); then go to OUTPUT.
REQ-012 OUTPUT pops the LIFO so bits leave in forward time order: the last pushed bit is first.
REQ-013 do_valid=1 throughout OUTPUT until the final transfer; a transfer occurs when do_valid & di_ready.
REQ-014 do_bit and do_last are held stable while do_valid=1 and di_ready=0.
REQ-015 do_last=1 only with the DECODE_LEN-th bit; after that transfer go to IDLE and drop do_busy the next cycle.
REQ-016 di_start in the same cycle as the last transfer is ignored, because the FSM is not yet in IDLE.
REQ-017 do_ram_rd=1 only during the DEPTH issue cycles.
REQ-018 Assertion checks: DECODE_LEN <= DEPTH, and DEPTH <= 2^ADDR_W.

Reset
REQ-019 While rst_n=0, regardless of state: state=IDLE; do_busy, do_ram_rd, do_valid, do_bit and do_last=0; do_ram_addr=0; LIFO pointer=0.
REQ-020 Reset asserted mid-TRACE or mid-OUTPUT aborts the run; no bit is emitted after reset release until a new di_start.

Configuration
REQ-021 Macro TBU_BEST_STATE_EN.
  Defined: initial state = di_best_state latched at start.
  Undefined: initial state = 6'd0, and di_best_state is unused.

Structure
REQ-022 global_define.vh holds:
  N_STATES=64, STATE_W=6
  FSM state encodings
  TBU_BEST_STATE_EN (when enabled)
REQ-023 The LIFO is the sub-module tbu_lifo with ports push, pop, din, dout, empty and param DEPTH. The state-update step stays inline.

Verification
REQ-024 All survivor words 0, best_state=0 -> 24 bits all 0; do_last on the 24th; do_busy low 1 cycle later.
REQ-025 All survivor words all-ones, best_state=0 -> state goes 0,1,3,7,15,31,63...; 24 bits all 1.
REQ-026 wr_ptr=2, ADDR_W=6 -> read addresses 2,1,0,63,...,19, exactly 48 reads with do_ram_rd high for 48 cycles.
REQ-027 Distinct pattern (survivor bit = state[0] of step parity) checked against a reference model -> forward-order output matches; di_ready low for 5 cycles mid-stream holds do_bit/do_valid stable.
REQ-028 rst_n pulled low at TRACE cycle 10 -> outputs 0 immediately; after release, no do_valid until a new di_start.
REQ-029 Build without TBU_BEST_STATE_EN and best_state=6'h3F -> output identical to the best_state=0 run; di_start while busy -> ignored.

Source files
------------

// File: rtl/tbu_ctrl_pkg.sv
// Shared trellis constants, FSM encoding and the traceback step for the
// Viterbi traceback controller (tbu_ctrl).
package tbu_ctrl_pkg;

   localparam int N_STATES = 64;
   localparam int STATE_W  = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACE  = 2'd1,
      ST_OUTPUT = 2'd2
   } fsm_t;

   // One traceback step: shift the survivor bit of the current state in at the LSB
   function automatic logic [STATE_W-1:0] trace_step(input logic [STATE_W-1:0]  st,
                                                      input logic [N_STATES-1:0] surv);
      return {st[STATE_W-2:0], surv[st]};
   endfunction

endpackage

// File: rtl/tbu_lifo.sv
// Bit-wide LIFO that reverses traceback order into forward time order.
// dout shows the top entry, and reads 0 when the LIFO is empty.
module tbu_lifo
   import tbu_ctrl_pkg::*;
#(
   parameter int DEPTH = 24
)(
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic empty
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] FULL = PW'(DEPTH);

   logic [PW-1:0] ptr;
   logic          mem [2**PW];

   assign empty = (ptr == '0);
   assign dout  = empty ? 1'b0 : mem[ptr - PW'(1)];

   // Stack pointer: the only control state, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (push && !pop && ptr != FULL) begin
         ptr <= ptr + PW'(1);
      end else if (pop && !push && !empty) begin
         ptr <= ptr - PW'(1);
      end
   end

   // Storage: data only, no reset needed
   always_ff @(posedge clk) begin
      if (push && ptr != FULL) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/tbu_ctrl.sv
// Viterbi traceback controller: walks DEPTH survivor words backwards from
// the newest write pointer, keeps the last DECODE_LEN decisions and emits
// them in forward time order over a valid/ready handshake.
// Build option: define TBU_BEST_STATE_EN to start the traceback from
// di_best_state; otherwise the traceback always starts in state 0.
module tbu_ctrl
   import tbu_ctrl_pkg::*;
#(
   parameter int DEPTH      = 48,
   parameter int DECODE_LEN = 24,
   parameter int ADDR_W     = 6
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                di_start,
   input  logic [ADDR_W-1:0]   di_wr_ptr,
   input  logic [STATE_W-1:0]  di_best_state,
   output logic                do_busy,
   output logic                do_ram_rd,
   output logic [ADDR_W-1:0]   do_ram_addr,
   input  logic [N_STATES-1:0] di_ram_data,
   output logic                do_valid,
   output logic                do_bit,
   output logic                do_last,
   input  logic                di_ready
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] LAST_RD   = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] TRACE_END = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] SKIP      = CNT_W'(DEPTH - DECODE_LEN);
   localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(DECODE_LEN - 2);

   if (DECODE_LEN > DEPTH) begin : g_chk_len
      $error("tbu_ctrl: DECODE_LEN must not exceed DEPTH");
   end
   if (DEPTH > 2**ADDR_W) begin : g_chk_depth
      $error("tbu_ctrl: DEPTH must not exceed the survivor RAM size");
   end
   if (DECODE_LEN < 1) begin : g_chk_min
      $error("tbu_ctrl: DECODE_LEN must be at least 1");
   end

   fsm_t               fsm;
   logic [CNT_W-1:0]   cnt;
   logic               vld_p1;
   logic [STATE_W-1:0] tb_state_p1;
   logic [STATE_W-1:0] start_state;
   logic               lifo_push;
   logic               lifo_pop;
   logic               lifo_dout;
   logic               lifo_empty;

`ifdef TBU_BEST_STATE_EN
   assign start_state = di_best_state;
`else
   logic unused_best_state;
   assign unused_best_state = ^di_best_state;
   assign start_state       = '0;
`endif

   // Only the last DECODE_LEN decisions are kept; earlier steps just converge
   assign lifo_push = vld_p1 && (cnt > SKIP);
   assign lifo_pop  = (fsm == ST_OUTPUT) && do_valid && di_ready;
   assign do_bit    = do_valid & ~lifo_empty & lifo_dout;

   tbu_lifo #(
      .DEPTH (DECODE_LEN)
   ) u_lifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (lifo_push),
      .pop   (lifo_pop),
      .din   (tb_state_p1[STATE_W-1]),
      .dout  (lifo_dout),
      .empty (lifo_empty)
   );

   // Control FSM: read issue (p0) and read-return tracking (p1), output handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= ST_IDLE;
         cnt         <= '0;
         vld_p1      <= 1'b0;
         do_busy     <= 1'b0;
         do_ram_rd   <= 1'b0;
         do_ram_addr <= '0;
         do_valid    <= 1'b0;
         do_last     <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (di_start) begin
                  fsm         <= ST_TRACE;
                  cnt         <= '0;
                  do_busy     <= 1'b1;
                  do_ram_rd   <= 1'b1;
                  do_ram_addr <= di_wr_ptr;
               end
            end
            ST_TRACE: begin
               cnt    <= cnt + 1'b1;
               vld_p1 <= do_ram_rd;
               if (do_ram_rd) begin
                  if (cnt == LAST_RD) begin
                     do_ram_rd <= 1'b0;
                  end else begin
                     do_ram_addr <= do_ram_addr - 1'b1;
                  end
               end
               if (cnt == TRACE_END) begin
                  fsm      <= ST_OUTPUT;
                  cnt      <= '0;
                  do_valid <= 1'b1;
                  do_last  <= (DECODE_LEN == 1);
               end
            end
            ST_OUTPUT: begin
               if (do_valid && di_ready) begin
                  if (do_last) begin
                     fsm      <= ST_IDLE;
                     do_valid <= 1'b0;
                     do_last  <= 1'b0;
                     do_busy  <= 1'b0;
                  end else begin
                     cnt     <= cnt + 1'b1;
                     do_last <= (cnt == LAST_OUT);
                  end
               end
            end
            default: fsm <= ST_IDLE;
         endcase
      end
   end

   // p1: trellis state walks back one step per returned survivor word
   always_ff @(posedge clk) begin
      if (fsm == ST_IDLE && di_start) begin
         tb_state_p1 <= start_state;
      end else if (vld_p1) begin
         tb_state_p1 <= trace_step(tb_state_p1, di_ram_data);
      end
   end

endmodule

// File: tb/tb_tbu_ctrl.sv
// Self-checking bench for tbu_ctrl: survivor RAM model, scoreboard of
// expected forward-order bits, and one task per scenario.
module tb_tbu_ctrl;

   localparam int DEPTH  = 48;
   localparam int DLEN   = 24;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              di_start = 1'b0;
   logic [ADDR_W-1:0] di_wr_ptr = '0;
   logic [5:0]        di_best_state = '0;
   logic              do_busy;
   logic              do_ram_rd;
   logic [ADDR_W-1:0] do_ram_addr;
   logic [63:0]       di_ram_data;
   logic              do_valid;
   logic              do_bit;
   logic              do_last;
   logic              di_ready = 1'b1;

   tbu_ctrl #(
      .DEPTH      (DEPTH),
      .DECODE_LEN (DLEN),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .di_start      (di_start),
      .di_wr_ptr     (di_wr_ptr),
      .di_best_state (di_best_state),
      .do_busy       (do_busy),
      .do_ram_rd     (do_ram_rd),
      .do_ram_addr   (do_ram_addr),
      .di_ram_data   (di_ram_data),
      .do_valid      (do_valid),
      .do_bit        (do_bit),
      .do_last       (do_last),
      .di_ready      (di_ready)
   );

   always #5 clk = ~clk;

   // Survivor RAM with one cycle of read latency
   logic [63:0] mem [64];
   logic [63:0] ram_q = '0;
   always @(posedge clk) if (do_ram_rd) ram_q <= mem[do_ram_addr];
   assign di_ram_data = ram_q;

   int          tests_run = 0;
   int          fails = 0;
   logic [1:0]  exp_q [$];      // {bit, last}
   logic [5:0]  addr_log [$];
   logic [1:0]  mon_e;

   always @(negedge clk) if (do_ram_rd) addr_log.push_back(do_ram_addr);

   // Scoreboard: every accepted bit is popped and compared
   always @(negedge clk) begin
      if (rst_n && do_valid && di_ready) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_xfer: got bit=%0b last=%0b, required no transfer", do_bit, do_last);
         end else begin
            mon_e = exp_q.pop_front();
            if ({do_bit, do_last} !== mon_e) begin
               fails++;
               $display("FAIL xfer: got bit=%0b last=%0b, required bit=%0b last=%0b",
                        do_bit, do_last, mon_e[1], mon_e[0]);
            end
            if (mon_e[0]) begin
               tests_run++;
               if (do_busy !== 1'b1) begin
                  fails++;
                  $display("FAIL busy_at_last: got %0b, required 1", do_busy);
               end
            end
         end
      end
   end

   function automatic logic [5:0] init_of(input logic [5:0] best);
`ifdef TBU_BEST_STATE_EN
      return best;
`else
      return 6'd0 & best;
`endif
   endfunction

   // Reference traceback: walk backwards, keep the tail, emit reversed
   function automatic void push_model(input logic [5:0] wr, input logic [5:0] init);
      logic [5:0] st;
      logic [5:0] a;
      logic       bits [DEPTH];
      st = init;
      for (int k = 0; k < DEPTH; k++) begin
         a       = wr - 6'(k);
         bits[k] = st[5];
         st      = {st[4:0], mem[a][st]};
      end
      for (int k = DEPTH - 1; k >= DEPTH - DLEN; k--)
         exp_q.push_back({bits[k], (k == DEPTH - DLEN) ? 1'b1 : 1'b0});
   endfunction

   task automatic pulse_start(input logic [5:0] wr, input logic [5:0] best);
      @(posedge clk); #1;
      di_wr_ptr = wr; di_best_state = best; di_start = 1'b1;
      @(posedge clk); #1;
      di_start = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #2;
         n++;
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: %0d bits outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic fill_random();
      for (int a = 0; a < 64; a++) mem[a] = {$urandom, $urandom};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({do_busy, do_ram_rd, do_valid, do_bit, do_last, do_ram_addr} !== '0) begin
         fails++;
         $display("FAIL reset_hold: got busy=%0b rd=%0b vld=%0b bit=%0b last=%0b addr=%0d, required all 0",
                  do_busy, do_ram_rd, do_valid, do_bit, do_last, do_ram_addr);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({do_busy, do_ram_rd, do_valid} !== 3'b000) begin
         fails++;
         $display("FAIL reset_idle: got busy=%0b rd=%0b vld=%0b, required 0 0 0", do_busy, do_ram_rd, do_valid);
      end
   endtask

   task automatic test_all_zero();
      for (int a = 0; a < 64; a++) mem[a] = 64'd0;
      for (int i = 0; i < DLEN; i++) exp_q.push_back({1'b0, (i == DLEN - 1) ? 1'b1 : 1'b0});
      pulse_start(6'd5, 6'd0);
      tests_run++;
      if (do_busy !== 1'b1) begin
         fails++;
         $display("FAIL zero_busy_start: got %0b, required 1", do_busy);
      end
      drain("zero");
      tests_run++;
      if ({do_busy, do_valid} !== 2'b00) begin
         fails++;
         $display("FAIL zero_busy_drop: got busy=%0b vld=%0b, required 0 0", do_busy, do_valid);
      end
   endtask

   task automatic test_all_ones();
      for (int a = 0; a < 64; a++) mem[a] = '1;
      for (int i = 0; i < DLEN; i++) exp_q.push_back({1'b1, (i == DLEN - 1) ? 1'b1 : 1'b0});
      pulse_start(6'd10, 6'd0);
      drain("ones");
   endtask

   task automatic test_addr_wrap();
      fill_random();
      addr_log.delete();
      push_model(6'd2, init_of(6'd0));
      pulse_start(6'd2, 6'd0);
      drain("addr");
      tests_run++;
      if (addr_log.size() != DEPTH) begin
         fails++;
         $display("FAIL addr_count: got %0d reads, required %0d", addr_log.size(), DEPTH);
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            logic [5:0] want;
            want = 6'd2 - 6'(k);
            tests_run++;
            if (addr_log[k] !== want) begin
               fails++;
               $display("FAIL addr_seq[%0d]: got %0d, required %0d", k, addr_log[k], want);
            end
         end
      end
   endtask

   task automatic test_pattern_stall();
      logic [2:0] held;
      int         n;
      for (int a = 0; a < 64; a++) mem[a] = a[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      mem[33] = 64'h0123_4567_89AB_CDEF;
      push_model(6'd37, init_of(6'h15));
      pulse_start(6'd37, 6'h15);
      n = 0;
      while (exp_q.size() > 14 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      di_ready = 1'b0;
      @(negedge clk);
      held = {do_valid, do_bit, do_last};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if ({do_valid, do_bit, do_last} !== held || held[2] !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got vld/bit/last=%b, required %b with vld=1",
                     i, {do_valid, do_bit, do_last}, held);
         end
      end
      @(posedge clk); #1;
      di_ready = 1'b1;
      drain("pattern");
   endtask

   task automatic test_reset_mid_trace();
      int seen;
      fill_random();
      pulse_start(6'd40, 6'd0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({do_busy, do_ram_rd, do_valid, do_bit, do_last, do_ram_addr} !== '0) begin
         fails++;
         $display("FAIL midreset_zero: got busy=%0b rd=%0b vld=%0b bit=%0b last=%0b addr=%0d, required all 0",
                  do_busy, do_ram_rd, do_valid, do_bit, do_last, do_ram_addr);
      end
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (do_valid || do_busy) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         fails++;
         $display("FAIL midreset_quiet: got %0d active cycles, required 0", seen);
      end
   endtask

   task automatic test_best_state_ignore_start();
      int n;
      int active;
      fill_random();
      push_model(6'd20, init_of(6'h3F));
      pulse_start(6'd20, 6'h3F);
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         di_wr_ptr = 6'd50;
         di_start  = (n == 5) || (n == 60) || (exp_q.size() == 1 && do_valid);
         n++;
      end
      di_start = 1'b0;
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL best_timeout: %0d bits outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      active = 0;
      repeat (60) begin
         @(negedge clk);
         if (do_busy || do_ram_rd) active++;
      end
      tests_run++;
      if (active != 0) begin
         fails++;
         $display("FAIL start_ignored: got %0d busy cycles after run, required 0", active);
      end
   endtask

   initial begin
      test_reset();
      test_all_zero();
      test_all_ones();
      test_addr_wrap();
      test_pattern_stall();
      test_reset_mid_trace();
      test_best_state_ignore_start();
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
